// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizes for the two-port SDRAM arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  localparam int ADDR_W_DEF = 27;
  localparam int DATA_W_DEF = 16;
  localparam int TMO_DEF    = 1023;

endpackage

// File: rtl/sdram_arb_rr_arb2.sv
// Two-way round-robin grant: on contention the port not granted last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // One-hot grant from the current requests and last-grant pointer
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/sdram_arb.sv
// Two-port round-robin front end for a single-command SDRAM controller,
// with a watchdog on the controller's completion handshake.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TMO    = TMO_DEF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        dvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              mem_rd,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              err
);

  localparam int WD_W = (TMO < 2) ? 1 : $clog2(TMO + 1);

  state_e            state_q, state_d;
  logic              g_q, g_d;          // granted port of the current transaction
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              last_q, last_d;    // 1 = port 1 was granted last
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [1:0]        dvalid_q, dvalid_d;
  logic              err_q, err_d;
  logic [1:0]        gnt;
  logic [1:0]        g_onehot;

  rr_arb2 u_arb (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign g_onehot = g_q ? 2'b10 : 2'b01;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign dout     = dout_q;
  assign dvalid   = dvalid_q;
  assign err      = err_q;

  // Next-state, latching and strobe decode for the transaction sequencer
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    last_d   = last_q;
    wd_d     = wd_q;
    dout_d   = dout_q;
    dvalid_d = 2'b00;
    err_d    = err_q;
    ack      = 2'b00;
    mem_we   = 1'b0;
    mem_rd   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_ready && (req != 2'b00)) begin
          g_d     = gnt[1];
          we_d    = gnt[0] ? we[0] : we[1];
          addr_d  = gnt[0] ? addr0 : addr1;
          din_d   = gnt[0] ? din0 : din1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_we  = we_q;
        mem_rd  = ~we_q;
        ack     = g_onehot;
        last_d  = g_q;
        state_d = S_GAP;
      end
      S_GAP: begin
        // Controller may still report ready from before the strobe
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_d = S_IDLE;
          if (!we_q) begin
            dout_d   = mem_dout;
            dvalid_d = g_onehot;
          end
        end else if (wd_q == WD_W'(TMO - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          if (!we_q) begin
            dout_d   = '0;
            dvalid_d = g_onehot;
          end
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      g_q      <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      last_q   <= 1'b1;
      wd_q     <= '0;
      dout_q   <= '0;
      dvalid_q <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      last_q   <= last_d;
      wd_q     <= wd_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 Parameter: ADDR_W, default 27, SDRAM word address width.
REQ-002 Parameter: DATA_W, default 16, SDRAM data width.
REQ-003 Parameter: TMO, default 1023, watchdog limit in clk_sys cycles while awaiting mem_ready.
REQ-004 clk_sys  in  1  sole clock; all logic on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 req[1:0]  in  2  per-port request, held until ack.
REQ-007 we[1:0]  in  2  per-port write (1) / read (0) select, stable while req.
REQ-008 addr0, addr1  in  ADDR_W each  per-port address, stable while req.
REQ-009 din0, din1  in  DATA_W each  per-port write data, stable while req.
REQ-010 ack[1:0]  out  2  one-cycle pulse: command accepted and issued.
REQ-011 dout  out  DATA_W  read data, shared by both ports.
REQ-012 dvalid[1:0]  out  2  one-cycle pulse: dout valid for that port.
REQ-013 mem_addr  out  ADDR_W  address to SDRAM controller.
REQ-014 mem_din  out  DATA_W  write data to SDRAM controller.
REQ-015 mem_we, mem_rd  out  1 each  one-cycle command strobes.
REQ-016 mem_ready  in  1  controller idle/complete.
REQ-017 mem_dout  in  DATA_W  controller read data.
REQ-018 err  out  1  sticky watchdog timeout flag.

Function
REQ-019 States: IDLE, ISSUE, GAP, WAIT.
REQ-020 IDLE: if mem_ready=1 and |req, latch the granted port's addr/din/we and go to ISSUE on the next edge; otherwise remain.
REQ-021 ISSUE: drive mem_we or mem_rd high for exactly this cycle, with mem_addr/mem_din valid, and ack[g]=1; next state GAP.
REQ-022 GAP: one cycle with mem_ready ignored, covering controller busy latency; next state WAIT.
REQ-023 WAIT: on mem_ready=1 return to IDLE; for a read, capture mem_dout into dout and pulse dvalid[g] in the same cycle as the transition.
REQ-024 Request-to-strobe latency is 1 cycle from the IDLE grant edge; minimum spacing between consecutive strobes is 4 cycles.
REQ-025 Arbitration is round-robin with a 1-bit last-grant pointer. On req=2'b11, grant the port not granted last. A single requester is always granted.
REQ-026 The last-grant pointer updates only in ISSUE.
REQ-027 A req deasserted before ack is dropped silently; no strobe is issued for it.
REQ-028 mem_addr/mem_din hold the latched values from ISSUE through WAIT.
REQ-029 Watchdog: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TMO: set err, go to IDLE, pulse dvalid[g] for reads with dout=0.
REQ-030 err clears only on reset.
REQ-031 dout holds its last captured value between reads.
REQ-032 mem_we and mem_rd are never both high.
REQ-033 ack and dvalid are never high for more than one cycle per transaction.

Reset
REQ-034 While reset_n=0 at an edge: state is IDLE; ack, dvalid, mem_we, mem_rd and err are 0; dout, mem_addr and mem_din are 0; the pointer selects port 1 as last grant, so port 0 wins the first contention.
REQ-035 Reset mid-transaction abandons it; no ack or dvalid is produced for that transaction.

Structure
REQ-036 Package sdram_arb_pkg holds the state enum, the ADDR_W/DATA_W defaults and the TMO default.
REQ-037 The grant logic lives in sub-module rr_arb2: inputs req[1:0] and last-grant; outputs one-hot grant. It is purely combinational and instantiated once.

Verification
REQ-038 Single write: port0 writes addr 'h4000000, data 3128, with mem_ready held 1 except 3 busy cycles after the strobe. Required: mem_we pulses once with that addr/data, ack[0] pulses on the same cycle, dvalid stays 0.
REQ-039 Read-back: port1 reads 'h2000000 and mem_dout=2064 when mem_ready returns. Required: dout=2064 with dvalid[1] pulsing in that cycle.
REQ-040 Contention: req=2'b11 held continuously from reset. Required: grants alternate 0,1,0,1 over four transactions, with strobes spaced at least 4 cycles apart.
REQ-041 Withdrawal: port0 asserts req for 1 cycle while mem_ready=0, then drops it. Required: no strobe and no ack.
REQ-042 Timeout with TMO=8: mem_ready is held 0 after a read strobe. Required: err=1 after 8 WAIT cycles, dvalid pulses with dout=0, state IDLE, and the next request is served.
REQ-043 Reset mid-WAIT: reset_n is pulled low for 1 cycle during WAIT. Required: all outputs 0, no dvalid, and the subsequent req=2'b11 grants port 0 first.
